nmr_qsw_en_wingen_param: RTL and testbench

Parametrised successor Q-switch enable window generator for the NMR receive path, in the ADC_CLK domain.
- Synchronises the asynchronous acquisition window, arms on a low-to-high transition, and applies a programmable pre-delay.
- Holds EN_QSW high until the pulsed acquisition marker arrives, then applies a programmable hold-off.
- Adds timeout protection, a software enable and status outputs. It sits between the acquisition sequencer and the Q-switch driver.

---
 rtl/nmr_qsw_en_wingen_param.sv | 162 ++++++++++++++++
 tb/tb_nmr_qsw_en_wingen_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_qsw_en_wingen_param.sv
// nmr_qsw_en_wingen_param
// Q-switch enable window generator for the NMR receive path (ADC_CLK domain).
// Synchronises ACQ_WND, arms on a fresh rising edge, waits a programmable
// pre-delay, holds EN_QSW until the acquisition marker plus a hold-off, and
// guards the active phase with an optional timeout.
// Optional feature macro: NMR_QSW_ECHO_CNT_EN (saturating completed-window count
// on ECHO_CNT; when undefined ECHO_CNT is tied to 0).
module nmr_qsw_en_wingen_param #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             ADC_CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             ACQ_WND,
   input  logic             ACQ_WND_PULSED,
   input  logic [CNT_W-1:0] DLY_CNT,
   input  logic [CNT_W-1:0] HOLD_CNT,
   input  logic [CNT_W-1:0] TMO_CNT,
   output logic             EN_QSW,
   output logic             BUSY,
   output logic             TIMEOUT,
   output logic [CNT_W-1:0] ECHO_CNT
);

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      ARMED  = 5'b00010,
      DELAY  = 5'b00100,
      ACTIVE = 5'b01000,
      HOLD   = 5'b10000
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   wnd_s;
   logic [CNT_W-1:0]       cnt_q;      // shared DELAY / HOLD down-counter
   logic [CNT_W-1:0]       hold_q;     // HOLD_CNT latched at ARMED exit
   logic [CNT_W-1:0]       tmo_q;      // TMO_CNT latched at ARMED exit
   logic [CNT_W-1:0]       tmo_ctr_q;  // cycles spent in ACTIVE
   logic                   timeout_q;
   logic                   arm_exit;
   logic                   pulse_exit;
   logic                   tmo_hit;

   // Multi-flop synchroniser bringing the asynchronous window into ADC_CLK
   always_ff @(posedge ADC_CLK or posedge RESET) begin
      if (RESET)
         sync_q <= '0;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], ACQ_WND};
   end

   assign wnd_s = sync_q[SYNC_STAGES-1];

   // State register
   always_ff @(posedge ADC_CLK or posedge RESET) begin
      if (RESET)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state decode and single-cycle event strobes for the datapath
   always_comb begin
      state_d    = state_q;
      arm_exit   = 1'b0;
      pulse_exit = 1'b0;
      tmo_hit    = 1'b0;
      if (!ENABLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // a window already high is ignored until it has been seen low
               if (!wnd_s)
                  state_d = ARMED;
            end
            ARMED: begin
               if (wnd_s) begin
                  arm_exit = 1'b1;
                  state_d  = (DLY_CNT == '0) ? ACTIVE : DELAY;
               end
            end
            DELAY: begin
               if (cnt_q == '0)
                  state_d = ACTIVE;
            end
            ACTIVE: begin
               // the marker takes priority over a timeout in the same cycle
               if (ACQ_WND_PULSED) begin
                  pulse_exit = 1'b1;
                  state_d    = (hold_q == '0) ? IDLE : HOLD;
               end else if ((tmo_q != '0) && (tmo_ctr_q == tmo_q - CNT_W'(1))) begin
                  tmo_hit = 1'b1;
                  state_d = IDLE;
               end
            end
            HOLD: begin
               if (cnt_q == '0)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Configuration latch, delay/hold down-counter, timeout counter and sticky flag
   always_ff @(posedge ADC_CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q     <= '0;
         hold_q    <= '0;
         tmo_q     <= '0;
         tmo_ctr_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (arm_exit) begin
            hold_q    <= HOLD_CNT;
            tmo_q     <= TMO_CNT;
            timeout_q <= 1'b0;
            cnt_q     <= (DLY_CNT == '0) ? '0 : DLY_CNT - CNT_W'(1);
         end else if (pulse_exit) begin
            cnt_q <= (hold_q == '0) ? '0 : hold_q - CNT_W'(1);
         end else if (((state_q == DELAY) || (state_q == HOLD)) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end

         // cleared on every entry into ACTIVE, frozen once the limit is reached
         if (arm_exit || ((state_q == DELAY) && (cnt_q == '0)))
            tmo_ctr_q <= '0;
         else if ((state_q == ACTIVE) && !tmo_hit && (tmo_ctr_q != '1))
            tmo_ctr_q <= tmo_ctr_q + CNT_W'(1);

         if (tmo_hit)
            timeout_q <= 1'b1;
      end
   end

`ifdef NMR_QSW_ECHO_CNT_EN
   logic [CNT_W-1:0] echo_q;

   // Saturating count of windows closed by the acquisition marker
   always_ff @(posedge ADC_CLK or posedge RESET) begin
      if (RESET)
         echo_q <= '0;
      else if (!ENABLE)
         echo_q <= '0;
      else if (pulse_exit && (echo_q != '1))
         echo_q <= echo_q + CNT_W'(1);
   end

   assign ECHO_CNT = echo_q;
`else
   assign ECHO_CNT = '0;
`endif

   // Moore outputs decoded straight from the state register so reset drops them at once
   assign EN_QSW  = (state_q == ACTIVE) || (state_q == HOLD);
   assign BUSY    = (state_q != IDLE);
   assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_nmr_qsw_en_wingen_param.sv
// Testbench for nmr_qsw_en_wingen_param: scoreboard of per-edge expected outputs
// derived from the window timing rules, compared at the falling edge.
module tb_nmr_qsw_en_wingen_param;
   localparam int SYNC = 2;
   localparam int CW   = 16;

   logic          ADC_CLK = 1'b0;
   logic          RESET;
   logic          ENABLE;
   logic          ACQ_WND;
   logic          ACQ_WND_PULSED;
   logic [CW-1:0] DLY_CNT;
   logic [CW-1:0] HOLD_CNT;
   logic [CW-1:0] TMO_CNT;
   logic          EN_QSW;
   logic          BUSY;
   logic          TIMEOUT;
   logic [CW-1:0] ECHO_CNT;

   nmr_qsw_en_wingen_param #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
      .ADC_CLK        (ADC_CLK),
      .RESET          (RESET),
      .ENABLE         (ENABLE),
      .ACQ_WND        (ACQ_WND),
      .ACQ_WND_PULSED (ACQ_WND_PULSED),
      .DLY_CNT        (DLY_CNT),
      .HOLD_CNT       (HOLD_CNT),
      .TMO_CNT        (TMO_CNT),
      .EN_QSW         (EN_QSW),
      .BUSY           (BUSY),
      .TIMEOUT        (TIMEOUT),
      .ECHO_CNT       (ECHO_CNT)
   );

   always #5 ADC_CLK = ~ADC_CLK;

   typedef struct {
      int            id;
      logic          en;
      logic          busy;
      logic          tmo;
      logic [CW-1:0] echo;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc_id   = 0;
   logic          exp_timeout;
   logic [CW-1:0] exp_echo;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] echo_inc(input logic [CW-1:0] v);
`ifdef NMR_QSW_ECHO_CNT_EN
      return (v == '1) ? v : v + CW'(1);
`else
      return v;
`endif
   endfunction

   task automatic push_exp(input logic en, input logic busy);
      exp_t e;
      e.id   = cyc_id;
      e.en   = en;
      e.busy = busy;
      e.tmo  = exp_timeout;
      e.echo = exp_echo;
      sb.push_back(e);
   endtask

   // drive one cycle of inputs, then record what must be visible after that edge
   task automatic step(input logic acq, input logic pulse, input logic ena,
                       input logic exp_en, input logic exp_busy);
      #1;
      ACQ_WND        = acq;
      ACQ_WND_PULSED = pulse;
      ENABLE         = ena;
      @(posedge ADC_CLK);
      cyc_id++;
      push_exp(exp_en, exp_busy);
   endtask

   // one window starting from ARMED with the synchronised window low;
   // edge 1 is the first edge sampling ACQ_WND=1, p = marker edge (0 = none),
   // dp = extra marker edge expected to be ignored
   task automatic run_window(input int dly, input int hold, input int tmo, input int p, input int dp);
      int en_rise;
      int t_exit;
      int e;
      bit by_pulse;
      en_rise  = SYNC + 1 + dly;
      t_exit   = (tmo != 0) ? en_rise + tmo : 32'h4000_0000;
      by_pulse = (p != 0) && (p <= t_exit);
      e        = by_pulse ? p + hold : t_exit;
      DLY_CNT  = CW'(dly);
      HOLD_CNT = CW'(hold);
      TMO_CNT  = CW'(tmo);
      for (int k = 1; k <= e + 2; k++) begin
         if (k == 4) begin
            #1;
            DLY_CNT  = CW'($urandom);
            HOLD_CNT = CW'($urandom);
            TMO_CNT  = CW'($urandom_range(1, 3));
         end
         if (k == 3) exp_timeout = 1'b0;
         if (!by_pulse && k == e) exp_timeout = 1'b1;
         if (by_pulse && k == p) exp_echo = echo_inc(exp_echo);
         step(k <= 3, (k == p) || (k == dp), 1'b1, (k >= en_rise) && (k < e), k != e);
      end
   endtask

   // compare every expected entry one half-cycle after its edge
   always @(negedge ADC_CLK) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         check_val($sformatf("en_qsw@%0d", mon_e.id), {31'b0, EN_QSW}, {31'b0, mon_e.en});
         check_val($sformatf("busy@%0d", mon_e.id), {31'b0, BUSY}, {31'b0, mon_e.busy});
         check_val($sformatf("timeout@%0d", mon_e.id), {31'b0, TIMEOUT}, {31'b0, mon_e.tmo});
         check_val($sformatf("echo_cnt@%0d", mon_e.id), {16'b0, ECHO_CNT}, {16'b0, mon_e.echo});
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, time %0t limit 400000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int dly, hold, tmo, p;
      RESET          = 1'b1;
      ENABLE         = 1'b0;
      ACQ_WND        = 1'b0;
      ACQ_WND_PULSED = 1'b0;
      DLY_CNT        = '0;
      HOLD_CNT       = '0;
      TMO_CNT        = '0;
      exp_timeout    = 1'b0;
      exp_echo       = '0;

      repeat (3) @(posedge ADC_CLK);
      @(negedge ADC_CLK);
      check_val("rst_en_qsw", {31'b0, EN_QSW}, 32'd0);
      check_val("rst_busy", {31'b0, BUSY}, 32'd0);
      check_val("rst_timeout", {31'b0, TIMEOUT}, 32'd0);
      check_val("rst_echo_cnt", {16'b0, ECHO_CNT}, 32'd0);
      @(posedge ADC_CLK);
      #1 RESET = 1'b0;

      // IDLE -> ARMED once enabled with the window low
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // directed windows
      run_window(0, 0, 0, 10, 0);   // minimum latency, marker at edge 10
      run_window(5, 3, 0, 12, 4);   // pre-delay, hold-off, marker in DELAY ignored
      run_window(0, 0, 4, 0, 0);    // timeout after exactly 4 ACTIVE cycles
      run_window(0, 0, 4, 7, 0);    // marker on 4th ACTIVE cycle beats timeout
      run_window(2, 1, 6, 0, 4);    // timeout after pre-delay
      run_window(1, 2, 5, 6, 0);    // marker before timeout, with hold-off

      // randomised windows
      for (int n = 0; n < 10; n++) begin
         dly  = $urandom_range(0, 6);
         hold = $urandom_range(0, 4);
         tmo  = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 10) : 0;
         p    = (tmo != 0 && $urandom_range(0, 3) == 0) ? 0 : SYNC + 1 + dly + 3 + $urandom_range(0, 6);
         run_window(dly, hold, tmo, p, (dly > 0) ? 4 : 0);
      end

      // disable, then enable while the window is already high
      exp_echo = '0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_window(3, 2, 0, 10, 4);

      // asynchronous reset while ACTIVE
      DLY_CNT  = '0;
      HOLD_CNT = '0;
      TMO_CNT  = '0;
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      exp_timeout = 1'b0;
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge ADC_CLK);
      #1 RESET = 1'b1;
      #1;
      check_val("async_rst_en_qsw", {31'b0, EN_QSW}, 32'd0);
      check_val("async_rst_busy", {31'b0, BUSY}, 32'd0);
      check_val("async_rst_echo_cnt", {16'b0, ECHO_CNT}, 32'd0);
      exp_timeout = 1'b0;
      exp_echo    = '0;
      @(posedge ADC_CLK);
      #1 RESET = 1'b0;

      // ENABLE dropped while in HOLD
      HOLD_CNT = CW'(5);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_echo = echo_inc(exp_echo);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      ACQ_WND_PULSED = 1'b0;
      ENABLE         = 1'b0;
      #1;
      check_val("hold_en_before_edge", {31'b0, EN_QSW}, 32'd1);
      exp_echo = '0;
      @(posedge ADC_CLK);
      cyc_id++;
      push_exp(1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge ADC_CLK);
      #1;
      check_val("sb_drain", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
